// File: rtl/get_reg.sv
// get_reg: RISC-V integer register index <-> ABI mnemonic translator.
// Names are packed ASCII, right-aligned, leading bytes zero. Both lookup
// paths are independent and fully registered with one-cycle latency.
module get_reg (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fwd_valid_i,
    input  logic [4:0]  fwd_idx_i,
    output logic        fwd_out_valid_o,
    output logic [31:0] fwd_name_o,
    output logic [2:0]  fwd_len_o,
    input  logic        rev_valid_i,
    input  logic [31:0] rev_name_i,
    output logic        rev_out_valid_o,
    output logic        rev_hit_o,
    output logic [4:0]  rev_idx_o
);

    localparam int unsigned NameW = 32;
    localparam int unsigned IdxW  = 5;
    localparam int unsigned LenW  = 3;
    localparam int unsigned NRegs = 32;

    // "fp" is the frame-pointer alias of s0 and only exists on the reverse path
    localparam logic [NameW-1:0] NameFp = 32'h0000_6670;
    localparam logic [IdxW-1:0]  IdxFp  = 5'd8;

    // Canonical ABI name for each integer register
    function automatic logic [NameW-1:0] abi_name(input logic [IdxW-1:0] idx);
        logic [NameW-1:0] n;
        case (idx)
            5'd0:    n = 32'h7A65_726F; // zero
            5'd1:    n = 32'h0000_7261; // ra
            5'd2:    n = 32'h0000_7370; // sp
            5'd3:    n = 32'h0000_6770; // gp
            5'd4:    n = 32'h0000_7470; // tp
            5'd5:    n = 32'h0000_7430; // t0
            5'd6:    n = 32'h0000_7431;
            5'd7:    n = 32'h0000_7432;
            5'd8:    n = 32'h0000_7330; // s0
            5'd9:    n = 32'h0000_7331;
            5'd10:   n = 32'h0000_6130; // a0
            5'd11:   n = 32'h0000_6131;
            5'd12:   n = 32'h0000_6132;
            5'd13:   n = 32'h0000_6133;
            5'd14:   n = 32'h0000_6134;
            5'd15:   n = 32'h0000_6135;
            5'd16:   n = 32'h0000_6136;
            5'd17:   n = 32'h0000_6137;
            5'd18:   n = 32'h0000_7332; // s2
            5'd19:   n = 32'h0000_7333;
            5'd20:   n = 32'h0000_7334;
            5'd21:   n = 32'h0000_7335;
            5'd22:   n = 32'h0000_7336;
            5'd23:   n = 32'h0000_7337;
            5'd24:   n = 32'h0000_7338;
            5'd25:   n = 32'h0000_7339;
            5'd26:   n = 32'h0073_3130; // s10
            5'd27:   n = 32'h0073_3131; // s11
            5'd28:   n = 32'h0000_7433; // t3
            5'd29:   n = 32'h0000_7434;
            5'd30:   n = 32'h0000_7435;
            default: n = 32'h0000_7436; // t6
        endcase
        return n;
    endfunction

    // Character count: only zero is four long, only s10/s11 are three long
    function automatic logic [LenW-1:0] abi_len(input logic [IdxW-1:0] idx);
        logic [LenW-1:0] l;
        case (idx)
            5'd0:         l = 3'd4;
            5'd26, 5'd27: l = 3'd3;
            default:      l = 3'd2;
        endcase
        return l;
    endfunction

    logic             fwd_vld_q, fwd_vld_d;
    logic [NameW-1:0] fwd_name_q, fwd_name_d;
    logic [LenW-1:0]  fwd_len_q, fwd_len_d;
    logic             rev_vld_q, rev_vld_d;
    logic             rev_hit_q, rev_hit_d;
    logic [IdxW-1:0]  rev_idx_q, rev_idx_d;

    logic             match_hit_c;
    logic [IdxW-1:0]  match_idx_c;

    // Reverse lookup: exact compare against every canonical name plus the fp alias
    always_comb begin
        match_hit_c = 1'b0;
        match_idx_c = '0;
        for (int i = 0; i < int'(NRegs); i++) begin
            if (rev_name_i == abi_name(IdxW'(i))) begin
                match_hit_c = 1'b1;
                match_idx_c = IdxW'(i);
            end
        end
        if (rev_name_i == NameFp) begin
            match_hit_c = 1'b1;
            match_idx_c = IdxFp;
        end
    end

    // Next-state: capture on valid, otherwise hold data and drop the valid flag
    always_comb begin
        fwd_vld_d  = fwd_valid_i;
        fwd_name_d = fwd_name_q;
        fwd_len_d  = fwd_len_q;
        rev_vld_d  = rev_valid_i;
        rev_hit_d  = rev_hit_q;
        rev_idx_d  = rev_idx_q;
        if (fwd_valid_i) begin
            fwd_name_d = abi_name(fwd_idx_i);
            fwd_len_d  = abi_len(fwd_idx_i);
        end
        if (rev_valid_i) begin
            rev_hit_d = match_hit_c;
            rev_idx_d = match_idx_c;
        end
    end

    // Output registers; reset has priority over any request in the same cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_vld_q  <= 1'b0;
            fwd_name_q <= '0;
            fwd_len_q  <= '0;
            rev_vld_q  <= 1'b0;
            rev_hit_q  <= 1'b0;
            rev_idx_q  <= '0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_name_q <= fwd_name_d;
            fwd_len_q  <= fwd_len_d;
            rev_vld_q  <= rev_vld_d;
            rev_hit_q  <= rev_hit_d;
            rev_idx_q  <= rev_idx_d;
        end
    end

    assign fwd_out_valid_o = fwd_vld_q;
    assign fwd_name_o      = fwd_name_q;
    assign fwd_len_o       = fwd_len_q;
    assign rev_out_valid_o = rev_vld_q;
    assign rev_hit_o       = rev_hit_q;
    assign rev_idx_o       = rev_idx_q;

endmodule

// File: tb/tb_get_reg.sv
// Testbench for get_reg: directed scenarios plus randomized traffic, checked
// against a string-table model of the ABI register names.
module tb_get_reg;

    logic        clk;
    logic        reset;
    logic        fwd_valid;
    logic [4:0]  fwd_idx;
    logic        fwd_out_valid;
    logic [31:0] fwd_name;
    logic [2:0]  fwd_len;
    logic        rev_valid;
    logic [31:0] rev_name;
    logic        rev_out_valid;
    logic        rev_hit;
    logic [4:0]  rev_idx;

    int n_cmp = 0;
    int n_bad = 0;

    get_reg dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .fwd_valid_i     (fwd_valid),
        .fwd_idx_i       (fwd_idx),
        .fwd_out_valid_o (fwd_out_valid),
        .fwd_name_o      (fwd_name),
        .fwd_len_o       (fwd_len),
        .rev_valid_i     (rev_valid),
        .rev_name_i      (rev_name),
        .rev_out_valid_o (rev_out_valid),
        .rev_hit_o       (rev_hit),
        .rev_idx_o       (rev_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ABI names in register order
    string names [32] = '{
        "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
        "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
        "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
        "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
    };

    // Expected output state held by the model
    logic        m_fov;
    logic [31:0] m_fname;
    logic [2:0]  m_flen;
    logic        m_rov;
    logic        m_rhit;
    logic [4:0]  m_ridx;

    function automatic logic [31:0] pack(input string s);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < s.len(); i++) v = (v << 8) | 32'(s[i]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then check every output
    task automatic cyc(input logic r, input logic fv, input logic [4:0] fi,
                       input logic rv, input logic [31:0] rn);
        reset = r; fwd_valid = fv; fwd_idx = fi; rev_valid = rv; rev_name = rn;
        @(posedge clk);
        #1;
        if (r) begin
            m_fov = 0; m_fname = 0; m_flen = 0;
            m_rov = 0; m_rhit = 0; m_ridx = 0;
        end else begin
            m_fov = fv;
            if (fv) begin
                m_fname = pack(names[fi]);
                m_flen  = 3'(names[fi].len());
            end
            m_rov = rv;
            if (rv) begin
                m_rhit = 0; m_ridx = 0;
                for (int i = 0; i < 32; i++)
                    if (pack(names[i]) == rn) begin m_rhit = 1; m_ridx = 5'(i); end
                if (rn == pack("fp")) begin m_rhit = 1; m_ridx = 5'd8; end
            end
        end
        chk("fwd_out_valid", 32'(fwd_out_valid), 32'(m_fov));
        chk("fwd_name",      fwd_name,           m_fname);
        chk("fwd_len",       32'(fwd_len),       32'(m_flen));
        chk("rev_out_valid", 32'(rev_out_valid), 32'(m_rov));
        chk("rev_hit",       32'(rev_hit),       32'(m_rhit));
        chk("rev_idx",       32'(rev_idx),       32'(m_ridx));
    endtask

    initial begin
        logic [31:0] rn;
        reset = 1; fwd_valid = 0; fwd_idx = 0; rev_valid = 0; rev_name = 0;
        m_fov = 0; m_fname = 0; m_flen = 0; m_rov = 0; m_rhit = 0; m_ridx = 0;

        // Reset with both valids high, then idle
        cyc(1, 1, 5'd2, 1, 32'h0000_7261);
        cyc(1, 1, 5'd3, 1, 32'h0000_7261);
        chk("reset_name_zero", fwd_name, 32'h0);
        cyc(0, 0, 5'd4, 0, 32'h0000_7370);
        cyc(0, 0, 5'd4, 0, 32'h0000_7370);
        chk("idle_name_zero", fwd_name, 32'h0);

        // Forward sweep, back-to-back
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 5'(i), 0, 32'h0);
            if (i == 0)  begin chk("lit_zero", fwd_name, 32'h7A65_726F); chk("lit_zero_len", 32'(fwd_len), 32'd4); end
            if (i == 1)  chk("lit_ra",  fwd_name, 32'h0000_7261);
            if (i == 26) begin chk("lit_s10", fwd_name, 32'h0073_3130); chk("lit_s10_len", 32'(fwd_len), 32'd3); end
            if (i == 31) chk("lit_t6",  fwd_name, 32'h0000_7436);
        end

        // Reverse sweep, alias, and misses
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 5'd0, 1, pack(names[i]));
            chk("rev_sweep_lit", 32'(rev_idx), i);
        end
        cyc(0, 0, 5'd0, 1, 32'h0000_6670);
        chk("lit_fp", 32'(rev_idx), 32'd8);
        cyc(0, 0, 5'd0, 1, 32'h0000_7330);
        chk("lit_s0", 32'(rev_idx), 32'd8);
        cyc(0, 0, 5'd0, 1, 32'h0000_7832);
        chk("miss_x2", 32'(rev_hit), 32'd0);
        cyc(0, 0, 5'd0, 1, 32'h0000_5241);
        chk("miss_RA", 32'(rev_hit), 32'd0);
        cyc(0, 0, 5'd0, 1, 32'h0100_7261);
        chk("miss_upper", 32'(rev_idx), 32'd0);

        // Concurrency, then hold
        cyc(0, 1, 5'd10, 1, 32'h0000_7436);
        chk("conc_a0", fwd_name, 32'h0000_6130);
        chk("conc_t6", 32'(rev_idx), 32'd31);
        cyc(0, 0, 5'd1, 0, 32'h0000_7261);
        chk("hold_a0", fwd_name, 32'h0000_6130);
        cyc(0, 0, 5'd1, 0, 32'h0000_7261);

        // Reset mid-stream
        cyc(0, 1, 5'd5, 1, 32'h0000_7261);
        cyc(1, 1, 5'd2, 0, 32'h0);
        chk("mid_reset_no_sp", fwd_name, 32'h0);
        cyc(0, 1, 5'd3, 0, 32'h0);
        chk("after_reset_gp", fwd_name, 32'h0000_6770);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: rn = pack(names[$urandom_range(0, 31)]);
                1: rn = $urandom;
                2: rn = 32'h0000_6670;
                default: rn = pack(names[$urandom_range(0, 31)]) ^ (32'h1 << $urandom_range(0, 31));
            endcase
            cyc(($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom), 1'($urandom), rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
